// File: rtl/opamp_mon_pkg.sv
// Register map, bit positions and default parameters for the opamp output monitor.
package opamp_mon_pkg;

    localparam int          DEF_FILT_W    = 4;
    localparam int          DEF_CNT_W     = 16;
    localparam logic [31:0] DEF_BASE_ADDR = 32'h3000_0000;

    // Byte offsets inside the 16-byte register window
    localparam logic [3:0] OFF_CTRL   = 4'h0;
    localparam logic [3:0] OFF_STATUS = 4'h4;
    localparam logic [3:0] OFF_RISE   = 4'h8;
    localparam logic [3:0] OFF_FALL   = 4'hC;

    // CTRL bit positions
    localparam int CTRL_EN       = 0;
    localparam int CTRL_FLEN_LSB = 4;
    localparam int CTRL_IRQ_RISE = 12;
    localparam int CTRL_IRQ_FALL = 13;

    // STATUS bit positions
    localparam int ST_FILT  = 0;
    localparam int ST_CMP_S = 1;
    localparam int ST_RISE  = 2;
    localparam int ST_FALL  = 3;

    // Expand Wishbone byte selects into a 32-bit bit mask
    function automatic logic [31:0] sel_mask(input logic [3:0] sel);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{sel[i]}};
        return m;
    endfunction

endpackage

// File: rtl/cmp_debounce.sv
// Comparator synchronizer plus stability-count debounce filter with edge events.
module cmp_debounce
    import opamp_mon_pkg::*;
#(
    parameter int FILT_W = DEF_FILT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmp_i,
    input  logic              en,
    input  logic [FILT_W-1:0] flen,
    output logic              filt_o,
    output logic              cmp_s_o,
    output logic              rise_o,
    output logic              fall_o
);

    logic [1:0]        r_sync;
    logic              r_filt;
    logic              r_en_d;
    logic [FILT_W-1:0] r_cnt;

    logic              w_cmp_s;
    logic [FILT_W-1:0] w_len;
    logic [FILT_W-1:0] w_cnt_inc;
    logic              w_toggle;

    assign w_cmp_s   = r_sync[1];
    assign w_len     = (flen == '0) ? FILT_W'(1) : flen;
    assign w_cnt_inc = r_cnt + FILT_W'(1);
    // No toggle on the enable cycle itself: filt just loads cmp_s there
    assign w_toggle  = en & r_en_d & (w_cmp_s != r_filt) & (w_cnt_inc == w_len);

    assign filt_o  = r_filt;
    assign cmp_s_o = w_cmp_s;
    assign rise_o  = w_toggle & ~r_filt;
    assign fall_o  = w_toggle &  r_filt;

    // Two-flop synchronizer, free running regardless of enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_sync <= '0;
        else        r_sync <= {r_sync[0], cmp_i};
    end

    // Stability counter and filtered output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_filt <= 1'b0;
            r_en_d <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_en_d <= en;
            if (!en) begin
                r_cnt <= '0;
            end else if (!r_en_d) begin
                r_filt <= w_cmp_s;
                r_cnt  <= '0;
            end else if (w_cmp_s == r_filt) begin
                r_cnt <= '0;
            end else if (w_toggle) begin
                r_filt <= ~r_filt;
                r_cnt  <= '0;
            end else begin
                r_cnt <= w_cnt_inc;
            end
        end
    end

endmodule

// File: rtl/opamp_out_monitor.sv
// Wishbone-mapped opamp comparator monitor: debounce, edge counters, flags, irq.
module opamp_out_monitor
    import opamp_mon_pkg::*;
#(
    parameter int          FILT_W    = DEF_FILT_W,
    parameter int          CNT_W     = DEF_CNT_W,
    parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n,
    input  logic        cmp_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        irq_o
);

    logic              r_ack;
    logic [31:0]       r_dat;
    logic              r_irq;
    logic              r_en;
    logic [FILT_W-1:0] r_flen;
    logic              r_irq_rise_en;
    logic              r_irq_fall_en;
    logic              r_rise_flag;
    logic              r_fall_flag;
    logic [CNT_W-1:0]  r_rise_cnt;
    logic [CNT_W-1:0]  r_fall_cnt;

    logic              w_filt, w_cmp_s, w_rise, w_fall;
    logic              w_req, w_hit, w_wr, w_rd;
    logic [3:0]        w_off;
    logic [31:0]       w_mask;
    logic [31:0]       w_ctrl_word, w_ctrl_new, w_status_word, w_rdata;
    logic              w_rise_clr, w_fall_clr, w_rcnt_clr, w_fcnt_clr;
    logic [CNT_W-1:0]  w_rise_base, w_fall_base, w_rise_nxt, w_fall_nxt;
    logic              w_unused;

    cmp_debounce #(.FILT_W(FILT_W)) u_deb (
        .clk     (wb_clk_i),
        .rst_n   (wb_rst_n),
        .cmp_i   (cmp_i),
        .en      (r_en),
        .flen    (r_flen),
        .filt_o  (w_filt),
        .cmp_s_o (w_cmp_s),
        .rise_o  (w_rise),
        .fall_o  (w_fall)
    );

    assign w_req  = wbs_cyc_i & wbs_stb_i & ~r_ack;
    assign w_hit  = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign w_off  = wbs_adr_i[3:0];
    assign w_wr   = w_req &  wbs_we_i & w_hit;
    assign w_rd   = w_req & ~wbs_we_i;
    assign w_mask = sel_mask(wbs_sel_i);

    assign w_rise_clr = w_wr && (w_off == OFF_STATUS) && wbs_sel_i[0] && wbs_dat_i[ST_RISE];
    assign w_fall_clr = w_wr && (w_off == OFF_STATUS) && wbs_sel_i[0] && wbs_dat_i[ST_FALL];
    assign w_rcnt_clr = w_wr && (w_off == OFF_RISE) && (wbs_sel_i != 4'b0);
    assign w_fcnt_clr = w_wr && (w_off == OFF_FALL) && (wbs_sel_i != 4'b0);

    // Only the field bits of the merged CTRL word are consumed
    assign w_unused = ^{w_ctrl_new, wbs_dat_i};

    // Register images, byte-merged CTRL and read mux
    always_comb begin
        w_ctrl_word = '0;
        w_ctrl_word[CTRL_EN]                   = r_en;
        w_ctrl_word[CTRL_FLEN_LSB +: FILT_W]   = r_flen;
        w_ctrl_word[CTRL_IRQ_RISE]             = r_irq_rise_en;
        w_ctrl_word[CTRL_IRQ_FALL]             = r_irq_fall_en;

        w_status_word = '0;
        w_status_word[ST_FILT]  = w_filt;
        w_status_word[ST_CMP_S] = w_cmp_s;
        w_status_word[ST_RISE]  = r_rise_flag;
        w_status_word[ST_FALL]  = r_fall_flag;

        w_ctrl_new = (w_ctrl_word & ~w_mask) | (wbs_dat_i & w_mask);

        w_rdata = '0;
        if (w_hit) begin
            case (w_off)
                OFF_CTRL:   w_rdata = w_ctrl_word;
                OFF_STATUS: w_rdata = w_status_word;
                OFF_RISE:   w_rdata = 32'(r_rise_cnt);
                OFF_FALL:   w_rdata = 32'(r_fall_cnt);
                default:    w_rdata = '0;
            endcase
        end
    end

    // Counter next state: clear first, then a saturating event increment
    always_comb begin
        w_rise_base = w_rcnt_clr ? '0 : r_rise_cnt;
        w_fall_base = w_fcnt_clr ? '0 : r_fall_cnt;
        w_rise_nxt  = w_rise_base;
        w_fall_nxt  = w_fall_base;
        if (w_rise && (w_rise_base != '1)) w_rise_nxt = w_rise_base + CNT_W'(1);
        if (w_fall && (w_fall_base != '1)) w_fall_nxt = w_fall_base + CNT_W'(1);
    end

    // Bus handshake: one-cycle ack, read data captured with it
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_ack <= 1'b0;
            r_dat <= '0;
        end else begin
            r_ack <= w_req;
            r_dat <= w_rd ? w_rdata : '0;
        end
    end

    // CTRL register, written at the ack edge
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_en          <= 1'b0;
            r_flen        <= '0;
            r_irq_rise_en <= 1'b0;
            r_irq_fall_en <= 1'b0;
        end else if (w_wr && (w_off == OFF_CTRL)) begin
            r_en          <= w_ctrl_new[CTRL_EN];
            r_flen        <= w_ctrl_new[CTRL_FLEN_LSB +: FILT_W];
            r_irq_rise_en <= w_ctrl_new[CTRL_IRQ_RISE];
            r_irq_fall_en <= w_ctrl_new[CTRL_IRQ_FALL];
        end
    end

    // Flags (set beats W1C), counters and registered interrupt
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_rise_flag <= 1'b0;
            r_fall_flag <= 1'b0;
            r_rise_cnt  <= '0;
            r_fall_cnt  <= '0;
            r_irq       <= 1'b0;
        end else begin
            r_rise_flag <= w_rise | (r_rise_flag & ~w_rise_clr);
            r_fall_flag <= w_fall | (r_fall_flag & ~w_fall_clr);
            r_rise_cnt  <= w_rise_nxt;
            r_fall_cnt  <= w_fall_nxt;
            r_irq       <= (r_rise_flag & r_irq_rise_en) | (r_fall_flag & r_irq_fall_en);
        end
    end

    assign wbs_ack_o = r_ack;
    assign wbs_dat_o = r_dat;
    assign irq_o     = r_irq;

endmodule

// File: tb/tb_opamp_out_monitor.sv
// Scenario bench for opamp_out_monitor with a read-expectation scoreboard.
module tb_opamp_out_monitor;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmp = 1'b0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = '0, wdat = '0;
    logic        ack, irq;
    logic [31:0] rdat;

    int checks = 0;
    int failures = 0;
    logic [31:0] sb_q[$];

    always #5 clk = ~clk;

    opamp_out_monitor #(.FILT_W(4), .CNT_W(4), .BASE_ADDR(BASE)) dut (
        .wb_clk_i  (clk),
        .wb_rst_n  (rst_n),
        .cmp_i     (cmp),
        .wbs_cyc_i (cyc),
        .wbs_stb_i (stb),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_adr_i (adr),
        .wbs_dat_i (wdat),
        .wbs_ack_o (ack),
        .wbs_dat_o (rdat),
        .irq_o     (irq)
    );

    task automatic wb_cycle(input logic w, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, output logic [31:0] q);
        bit got = 0;
        @(negedge clk);
        cyc = 1; stb = 1; we = w; adr = a; wdat = d; sel = s;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ack) begin got = 1; break; end
        end
        q = rdat;
        cyc = 0; stb = 0; we = 0;
        if (!got) begin
            checks++; failures++;
            $display("FAIL bus_timeout: ack=0 required ack=1 at adr %h", a);
        end
    endtask

    task automatic wb_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] q;
        wb_cycle(1'b1, a, d, s, q);
    endtask

    task automatic wb_rd(input logic [31:0] a, output logic [31:0] q);
        wb_cycle(1'b0, a, 32'h0, 4'hF, q);
    endtask

    // Scoreboarded read: expectation queued before the transfer, popped at ack
    task automatic rd_expect(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] q, e;
        sb_q.push_back(exp);
        wb_rd(a, q);
        e = sb_q.pop_front();
        checks++;
        if (q !== e) begin
            failures++;
            $display("FAIL %s: got %h required %h", name, q, e);
        end
    endtask

    task automatic clear_all();
        wb_wr(BASE + 4, 32'hC, 4'hF);
        wb_wr(BASE + 8, 32'h0, 4'hF);
        wb_wr(BASE + 12, 32'h0, 4'hF);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({ack, irq, rdat} !== 34'h0) begin
            failures++;
            $display("FAIL reset_outputs: got ack=%b irq=%b dat=%h required 0", ack, irq, rdat);
        end
        rst_n = 1'b1;
        rd_expect("reset_ctrl",   BASE + 0,  32'h0);
        rd_expect("reset_status", BASE + 4,  32'h0);
        rd_expect("reset_rise",   BASE + 8,  32'h0);
        rd_expect("reset_fall",   BASE + 12, 32'h0);
    endtask

    task automatic test_rise();
        wb_wr(BASE, 32'h0041, 4'hF);
        repeat (2) @(negedge clk);
        cmp = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            if (k == 5) begin
                checks++;
                if (dut.u_deb.filt_o !== 1'b0) begin
                    failures++;
                    $display("FAIL rise_filt_early: filt=%b required 0 at cycle 5", dut.u_deb.filt_o);
                end
            end
            if (k == 6) begin
                checks++;
                if (dut.u_deb.filt_o !== 1'b1) begin
                    failures++;
                    $display("FAIL rise_filt_time: filt=%b required 1 at cycle 6", dut.u_deb.filt_o);
                end
            end
        end
        rd_expect("rise_cnt",    BASE + 8, 32'h1);
        rd_expect("rise_status", BASE + 4, 32'h7);
        wb_wr(BASE + 4, 32'h4, 4'hF);
        cmp = 1'b0;
        repeat (10) @(negedge clk);
        rd_expect("fall_cnt",    BASE + 12, 32'h1);
        rd_expect("fall_status", BASE + 4,  32'h8);
        clear_all();
        rd_expect("cnt_cleared", BASE + 12, 32'h0);
    endtask

    task automatic test_glitch();
        @(negedge clk); cmp = 1'b1;
        repeat (3) @(negedge clk); cmp = 1'b0;
        repeat (10) @(negedge clk);
        rd_expect("glitch3_rise", BASE + 8, 32'h0);
        @(negedge clk); cmp = 1'b1;
        repeat (4) @(negedge clk); cmp = 1'b0;
        repeat (12) @(negedge clk);
        rd_expect("pulse4_rise", BASE + 8, 32'h1);
        clear_all();
    endtask

    task automatic test_saturate();
        wb_wr(BASE, 32'h0011, 4'hF);
        repeat (2) @(negedge clk);
        for (int n = 0; n < 20; n++) begin
            cmp = 1'b1; repeat (5) @(negedge clk);
            cmp = 1'b0; repeat (5) @(negedge clk);
        end
        rd_expect("sat_rise", BASE + 8,  32'hF);
        rd_expect("sat_fall", BASE + 12, 32'hF);
        // Clear write committed on the same edge as the rise event
        @(negedge clk); cmp = 1'b1;
        @(negedge clk);
        @(negedge clk);
        cyc = 1; stb = 1; we = 1; adr = BASE + 8; wdat = 0; sel = 4'hF;
        @(negedge clk);
        checks++;
        if (ack !== 1'b1) begin
            failures++;
            $display("FAIL clr_event_ack: ack=%b required 1", ack);
        end
        cyc = 0; stb = 0; we = 0;
        cmp = 1'b0;
        repeat (6) @(negedge clk);
        rd_expect("clr_with_event", BASE + 8, 32'h1);
        clear_all();
    endtask

    task automatic test_irq();
        bit seen = 0;
        wb_wr(BASE, 32'h1011, 4'hF);
        repeat (2) @(negedge clk);
        cmp = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            if (k == 3) begin
                checks++;
                if (irq !== 1'b0) begin
                    failures++;
                    $display("FAIL irq_latency_early: irq=%b required 0", irq);
                end
            end
            if (k == 4) begin
                checks++;
                if (irq !== 1'b1) begin
                    failures++;
                    $display("FAIL irq_assert: irq=%b required 1", irq);
                end
            end
        end
        wb_wr(BASE + 4, 32'h4, 4'hF);
        @(posedge clk); #1;
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL irq_w1c: irq=%b required 0", irq);
        end
        @(negedge clk); cmp = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (irq) seen = 1;
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL irq_fall_masked: irq=1 seen required 0");
        end
        rd_expect("irq_fall_status", BASE + 4, 32'h8);
    endtask

    task automatic test_bus();
        @(negedge clk);
        cyc = 1; stb = 1; we = 0; adr = BASE + 32'h10; sel = 4'hF;
        @(posedge clk); #1;
        checks++;
        if (ack !== 1'b1 || rdat !== 32'h0) begin
            failures++;
            $display("FAIL oob_read: ack=%b dat=%h required ack=1 dat=0", ack, rdat);
        end
        @(posedge clk); #1;
        checks++;
        if (ack !== 1'b0) begin
            failures++;
            $display("FAIL no_b2b_ack: ack=%b required 0", ack);
        end
        @(negedge clk); cyc = 0; stb = 0;
        wb_wr(BASE, 32'hFFFF_FFFF, 4'h0);
        rd_expect("ctrl_sel0", BASE, 32'h1011);
        wb_wr(BASE + 32'h100, 32'h0, 4'hF);
        rd_expect("ctrl_oob_wr", BASE, 32'h1011);
        wb_wr(BASE, 32'h0000_3FFF, 4'h1);
        rd_expect("ctrl_byte0", BASE, 32'h10F1);
        rd_expect("unmapped_off", BASE + 1, 32'h0);
    endtask

    task automatic test_reset_mid();
        bit seen = 0;
        wb_wr(BASE, 32'h1041, 4'hF);
        wb_wr(BASE + 4, 32'hC, 4'hF);
        repeat (2) @(negedge clk);
        cmp = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_irq: irq=%b required 1", irq);
        end
        cmp = 1'b0;
        repeat (3) @(negedge clk);
        cyc = 1; stb = 1; we = 0; adr = BASE + 4; sel = 4'hF;
        @(posedge clk); #2;
        checks++;
        if (ack !== 1'b1 || rdat === 32'h0) begin
            failures++;
            $display("FAIL pre_reset_ack: ack=%b dat=%h required ack=1 dat!=0", ack, rdat);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ack, irq, rdat, dut.u_deb.filt_o} !== 35'h0) begin
            failures++;
            $display("FAIL reset_mid: ack=%b irq=%b dat=%h filt=%b required 0",
                     ack, irq, rdat, dut.u_deb.filt_o);
        end
        @(negedge clk); cyc = 0; stb = 0;
        @(negedge clk); rst_n = 1'b1;
        cmp = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (ack) seen = 1;
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL ack_after_reset: ack=1 seen required 0");
        end
        rd_expect("post_reset_ctrl", BASE, 32'h0);
        repeat (8) @(negedge clk);
        rd_expect("post_reset_rise", BASE + 8, 32'h0);
        rd_expect("post_reset_status", BASE + 4, 32'h2);
    endtask

    initial begin
        test_reset();
        test_rise();
        test_glitch();
        test_saturate();
        test_irq();
        test_bus();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
